// File: rtl/cascade_counter.sv
// Multi-digit modulo-RADIX counter: DIGITS cascaded digits with up/down,
// clear, clamped parallel load, wrap/saturate at terminal count and sticky overflow.
module cascade_counter #(
  parameter int DIGITS   = 4,
  parameter int RADIX    = 10,
  parameter int DW       = $clog2(RADIX),
  parameter int SATURATE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ena,
  input  logic                 dir,
  input  logic                 clr,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] num,
  output logic                 carry,
  output logic                 ovf
);

  localparam logic [DW-1:0] DMAX = DW'(RADIX - 1);
  localparam logic [DW-1:0] DONE = DW'(1);

  logic [DIGITS*DW-1:0] num_q, num_d;
  logic                 ovf_q, ovf_d;
  logic [DIGITS:0]      t;
  logic                 terminal;

  // t[i] is high when every lower digit sits at its terminal value for the current direction
  always_comb begin
    t    = '0;
    t[0] = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      t[i+1] = t[i] && (dir ? (num_q[i*DW +: DW] == '0)
                            : (num_q[i*DW +: DW] == DMAX));
    end
  end

  assign terminal = t[DIGITS];
  assign carry    = ena && !clr && !load && terminal;

  always_comb begin
    num_d = num_q;
    ovf_d = ovf_q;
    if (clr) begin
      num_d = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        num_d[i*DW +: DW] = (load_val[i*DW +: DW] > DMAX) ? DMAX : load_val[i*DW +: DW];
      end
      ovf_d = 1'b0;
    end else if (ena) begin
      if (carry) begin
        ovf_d = 1'b1;
      end
      // saturating instances freeze at terminal; otherwise every digit with t[i] steps
      if (!(terminal && (SATURATE != 0))) begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (t[i]) begin
            if (dir) begin
              num_d[i*DW +: DW] = (num_q[i*DW +: DW] == '0) ? DMAX
                                                            : num_q[i*DW +: DW] - DONE;
            end else begin
              num_d[i*DW +: DW] = (num_q[i*DW +: DW] == DMAX) ? '0
                                                              : num_q[i*DW +: DW] + DONE;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      num_q <= num_d;
      ovf_q <= ovf_d;
    end
  end

  assign num = num_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_cascade_counter.sv
// Bench for cascade_counter: integer-valued reference model checked every cycle
// on two instances (2x decimal wrapping, 3x radix-6 saturating) plus directed literals.
module tb_cascade_counter;

  localparam int AD = 2;
  localparam int AR = 10;
  localparam int AW = 4;
  localparam int BD = 3;
  localparam int BR = 6;
  localparam int BW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic a_ena = 1'b0, a_dir = 1'b0, a_clr = 1'b0, a_load = 1'b0;
  logic [AD*AW-1:0] a_lv = '0;
  logic [AD*AW-1:0] a_num;
  logic a_carry, a_ovf;

  logic b_ena = 1'b0, b_dir = 1'b0, b_clr = 1'b0, b_load = 1'b0;
  logic [BD*BW-1:0] b_lv = '0;
  logic [BD*BW-1:0] b_num;
  logic b_carry, b_ovf;

  int n_checks = 0;
  int n_err = 0;

  int ma_val = 0;
  bit ma_ovf = 1'b0;
  int mb_val = 0;
  bit mb_ovf = 1'b0;

  always #5 clk = ~clk;

  cascade_counter #(.DIGITS(AD), .RADIX(AR), .SATURATE(0)) dut_a (
    .clk(clk), .reset(reset), .ena(a_ena), .dir(a_dir), .clr(a_clr), .load(a_load),
    .load_val(a_lv), .num(a_num), .carry(a_carry), .ovf(a_ovf)
  );

  cascade_counter #(.DIGITS(BD), .RADIX(BR), .SATURATE(1)) dut_b (
    .clk(clk), .reset(reset), .ena(b_ena), .dir(b_dir), .clr(b_clr), .load(b_load),
    .load_val(b_lv), .num(b_num), .carry(b_carry), .ovf(b_ovf)
  );

  function automatic int top_val(input int r, input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * r;
    return p - 1;
  endfunction

  function automatic bit is_term(input int v, input bit dir, input int r, input int d);
    return dir ? (v == 0) : (v == top_val(r, d));
  endfunction

  function automatic bit exp_carry(input int v, input bit ena, input bit dir, input bit clr,
                                   input bit load, input int r, input int d);
    return ena && !clr && !load && is_term(v, dir, r, d);
  endfunction

  function automatic int decode(input logic [63:0] lv, input int r, input int d, input int dw);
    int acc = 0;
    for (int i = d - 1; i >= 0; i--) begin
      int dig;
      dig = int'((lv >> (i * dw)) & ((64'd1 << dw) - 64'd1));
      if (dig > r - 1) dig = r - 1;
      acc = acc * r + dig;
    end
    return acc;
  endfunction

  function automatic logic [63:0] pack(input int v, input int r, input int d, input int dw);
    logic [63:0] o = '0;
    int x = v;
    for (int i = 0; i < d; i++) begin
      o = o | (64'(x % r) << (i * dw));
      x = x / r;
    end
    return o;
  endfunction

  function automatic int next_val(input int v, input bit ena, input bit dir, input bit clr,
                                  input bit load, input logic [63:0] lv, input int r,
                                  input int d, input int dw, input bit sat);
    if (clr) return 0;
    if (load) return decode(lv, r, d, dw);
    if (!ena) return v;
    if (is_term(v, dir, r, d)) return sat ? v : (dir ? top_val(r, d) : 0);
    return dir ? v - 1 : v + 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ma_val <= 0;
      ma_ovf <= 1'b0;
      mb_val <= 0;
      mb_ovf <= 1'b0;
    end else begin
      ma_ovf <= (a_clr || a_load) ? 1'b0
                : (ma_ovf | exp_carry(ma_val, a_ena, a_dir, a_clr, a_load, AR, AD));
      ma_val <= next_val(ma_val, a_ena, a_dir, a_clr, a_load, 64'(a_lv), AR, AD, AW, 1'b0);
      mb_ovf <= (b_clr || b_load) ? 1'b0
                : (mb_ovf | exp_carry(mb_val, b_ena, b_dir, b_clr, b_load, BR, BD));
      mb_val <= next_val(mb_val, b_ena, b_dir, b_clr, b_load, 64'(b_lv), BR, BD, BW, 1'b1);
    end
  end

  always @(negedge clk) begin
    chk("a_num", 64'(a_num), pack(ma_val, AR, AD, AW));
    chk("a_carry", 64'(a_carry), 64'(exp_carry(ma_val, a_ena, a_dir, a_clr, a_load, AR, AD)));
    chk("a_ovf", 64'(a_ovf), 64'(ma_ovf));
    chk("b_num", 64'(b_num), pack(mb_val, BR, BD, BW));
    chk("b_carry", 64'(b_carry), 64'(exp_carry(mb_val, b_ena, b_dir, b_clr, b_load, BR, BD)));
    chk("b_ovf", 64'(b_ovf), 64'(mb_ovf));
  end

  initial begin
    tick(2);
    reset = 1'b0;
    chk("rst_a_num", 64'(a_num), 64'h0);
    chk("rst_a_ovf", 64'(a_ovf), 64'h0);
    chk("rst_b_num", 64'(b_num), 64'h0);

    // full decimal sweep up
    a_ena = 1'b1;
    tick(99);
    chk("up_99_num", 64'(a_num), 64'h99);
    chk("up_99_carry", 64'(a_carry), 64'h1);
    chk("up_99_ovf", 64'(a_ovf), 64'h0);
    tick(1);
    chk("up_wrap_num", 64'(a_num), 64'h00);
    chk("up_wrap_ovf", 64'(a_ovf), 64'h1);
    a_ena = 1'b0;

    // clamped load then count down through zero
    a_lv = {4'd15, 4'd3};
    a_load = 1'b1;
    tick(1);
    a_load = 1'b0;
    chk("load_clamp_num", 64'(a_num), 64'h93);
    chk("load_clamp_ovf", 64'(a_ovf), 64'h0);
    a_dir = 1'b1;
    a_ena = 1'b1;
    tick(93);
    chk("dn_00_num", 64'(a_num), 64'h00);
    chk("dn_00_carry", 64'(a_carry), 64'h1);
    tick(1);
    chk("dn_wrap_num", 64'(a_num), 64'h99);
    chk("dn_wrap_ovf", 64'(a_ovf), 64'h1);
    a_ena = 1'b0;
    a_dir = 1'b0;

    // priority: clr over load over ena
    a_lv = 8'h42;
    a_load = 1'b1;
    tick(1);
    a_clr = 1'b1;
    a_ena = 1'b1;
    #1;
    chk("prio_carry", 64'(a_carry), 64'h0);
    tick(1);
    chk("prio_clr_num", 64'(a_num), 64'h00);
    chk("prio_clr_ovf", 64'(a_ovf), 64'h0);
    a_clr = 1'b0;
    a_ena = 1'b0;
    a_lv = 8'h99;
    tick(1);
    a_ena = 1'b1;
    a_lv = 8'h25;
    #1;
    chk("load_term_carry", 64'(a_carry), 64'h0);
    tick(1);
    chk("load_term_num", 64'(a_num), 64'h25);
    a_load = 1'b0;
    a_ena = 1'b0;

    // gated stepping with direction flips at the 09/10 boundary
    a_lv = 8'h08;
    a_load = 1'b1;
    tick(1);
    a_load = 1'b0;
    a_ena = 1'b1; tick(1);
    chk("gate_09a", 64'(a_num), 64'h09);
    a_ena = 1'b0; tick(1);
    chk("gate_hold", 64'(a_num), 64'h09);
    a_ena = 1'b1; tick(1);
    chk("gate_10a", 64'(a_num), 64'h10);
    a_ena = 1'b0; a_dir = 1'b1; tick(1);
    a_ena = 1'b1; tick(1);
    chk("gate_09b", 64'(a_num), 64'h09);
    a_ena = 1'b0; a_dir = 1'b0; tick(1);
    a_ena = 1'b1; tick(1);
    chk("gate_10b", 64'(a_num), 64'h10);
    a_ena = 1'b0;

    // async reset mid-cycle with ovf set
    a_lv = 8'h99;
    a_load = 1'b1;
    tick(1);
    a_load = 1'b0;
    a_ena = 1'b1;
    tick(58);
    a_ena = 1'b0;
    chk("pre_rst_num", 64'(a_num), 64'h57);
    chk("pre_rst_ovf", 64'(a_ovf), 64'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_num", 64'(a_num), 64'h00);
    chk("async_rst_ovf", 64'(a_ovf), 64'h0);
    chk("async_rst_carry", 64'(a_carry), 64'h0);
    tick(1);
    reset = 1'b0;
    a_ena = 1'b1;
    tick(5);
    chk("resume_num", 64'(a_num), 64'h05);
    a_ena = 1'b0;

    // saturating radix-6 instance
    b_lv = {3'd5, 3'd5, 3'd4};
    b_load = 1'b1;
    tick(1);
    b_load = 1'b0;
    chk("sat_load", 64'(b_num), 64'({3'd5, 3'd5, 3'd4}));
    b_ena = 1'b1;
    tick(1);
    chk("sat_555", 64'(b_num), 64'({3'd5, 3'd5, 3'd5}));
    chk("sat_555_carry", 64'(b_carry), 64'h1);
    chk("sat_555_ovf", 64'(b_ovf), 64'h0);
    tick(3);
    chk("sat_hold", 64'(b_num), 64'({3'd5, 3'd5, 3'd5}));
    chk("sat_hold_carry", 64'(b_carry), 64'h1);
    chk("sat_hold_ovf", 64'(b_ovf), 64'h1);
    b_lv = {3'd7, 3'd0, 3'd6};
    b_load = 1'b1;
    tick(1);
    b_load = 1'b0;
    chk("sat_clamp", 64'(b_num), 64'({3'd5, 3'd0, 3'd5}));
    chk("sat_clamp_ovf", 64'(b_ovf), 64'h0);
    b_dir = 1'b1;
    tick(12);
    chk("sat_dn", 64'(b_num), 64'({3'd4, 3'd4, 3'd5}));
    b_ena = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
